game_state_ctrl: RTL and testbench
==================================

// Module: game_state_ctrl
// PURPOSE
//  Parametrised game-flow controller for the Pac-Man display/logic path. Sits between the sprite
//  location controllers (pacman_loc_ctrl, ghosts_ai), map_RAM_writer and the HEX displays.
//  Detects pac/ghost collisions for N ghosts and tracks lives, respawn delay, win and game-over.
//  Each collision event costs at most one life; frightened-mode collisions report ghost kills.
// PARAMETERS
//  NUM_GHOSTS     2          number of ghost channels (1..8)
//  X_W            6          tile x-coordinate width (0..39)
//  Y_W            5          tile y-coordinate width (0..29)
//  PILL_W         33         width of frightened-timer input
//  PEL_W          10         width of remaining-pellet count
//  LIVES_INIT     3          lives loaded in INIT (1..7)
//  RESUME_CYCLES  250000000  CLOCK_50 cycles spent in RESUME (5 s); must be >= 2
// PORTS
//  CLOCK_50      in   1                 system clock, all state updates on rising edge
//  reset_n       in   1                 asynchronous active-low reset
//  start         in   1                 level; game-enable switch
//  pac_x         in   X_W               pacman next tile x
//  pac_y         in   Y_W               pacman next tile y
//  ghost_x       in   NUM_GHOSTS*X_W    ghost i next x at [i*X_W +: X_W]
//  ghost_y       in   NUM_GHOSTS*Y_W    ghost i next y at [i*Y_W +: Y_W]
//  pill_count    in   PILL_W            frightened timer; nonzero = ghosts vulnerable
//  pellets_left  in   PEL_W             pellets remaining on map
//  lives         out  3                 remaining lives
//  state         out  3                 0 INIT,1 GAME,2 RESUME,3 OVER,4 WIN
//  sprite_reset  out  1                 hold sprite controllers at spawn
//  map_wr_reset  out  1                 reset map writer / reload map
//  score_reset   out  1                 clear pill counter/score
//  ghost_enable  out  1                 ghost AI may move
//  ghost_eaten   out  NUM_GHOSTS        1-cycle pulse: ghost i eaten while frightened
//  life_lost     out  1                 1-cycle pulse on each life decrement
// BEHAVIOUR
//  - All outputs registered. Reset: state=INIT, lives=LIVES_INIT, sprite_reset=1, map_wr_reset=1,
//    score_reset=1, ghost_enable=0, ghost_eaten=0, life_lost=0, resume counter=0.
//  - hit[i] = (ghost_x[i]==pac_x)&&(ghost_y[i]==pac_y), combinational; any_hit = |hit.
//  - Edge qualification: hit_q[i] registered each cycle; event[i] = hit[i] & ~hit_q[i].
//    hit_q forced to 0 outside GAME, so a stale overlap on GAME entry counts once.
//  - INIT: sprite/map/score resets=1, ghost_enable=0, lives<=LIVES_INIT. start=1 -> GAME.
//  - GAME: all resets 0, ghost_enable=1. Priority per cycle, highest first:
//    1) pellets_left==0 -> WIN.
//    2) any event with pill_count!=0 -> ghost_eaten[i]<=event[i] (all simultaneous i), stay GAME.
//    3) any event with pill_count==0 -> life_lost pulse; lives>1: lives-1, counter<=RESUME_CYCLES-1,
//       map_wr_reset pulses 1 cycle, -> RESUME; lives==1: lives<=0 -> OVER.
//       Multiple ghosts hitting same cycle = one life.
//  - RESUME: sprite_reset=1, ghost_enable=0, counter decrements; counter==0 -> GAME (exactly
//    RESUME_CYCLES cycles in RESUME). Collisions ignored.
//  - OVER / WIN: ghost_enable=0, map_wr_reset=1, sprite_reset=0, lives held. start=0 -> INIT.
//  - start dropping during GAME/RESUME has no effect; only reset_n aborts mid-game.
//  - reset_n asserted anywhere returns to reset values immediately (async), pulses cancelled.
//  - lives never underflows; counter width = $clog2(RESUME_CYCLES).
// CONFIGURATION
//  GAME_STATE_PAUSE_EN defined: adds input `pause` (1 bit). In GAME, pause=1 freezes the FSM:
//    ghost_enable=0, no collisions processed, hit_q held; in RESUME the counter holds.
//    Release resumes exactly where frozen. Not defined: no pause port, behaviour as above.
// TESTING
//  T1 reset_n=0 then 1, start=1 -> INIT one cycle, then state=1, lives=3, ghost_enable=1.
//  T2 GAME, pill_count=0, ghost0 onto pac for 10 cycles -> one life_lost, lives=2, RESUME for
//     RESUME_CYCLES (set 8) cycles, then GAME.
//  T3 ghost0 and ghost1 hit pac same cycle, pill_count=0 -> lives 3->2 only.
//  T4 pill_count=50, ghost1 hits -> ghost_eaten=2'b10 for one cycle, lives unchanged, state GAME.
//  T5 lives=1, hit with pill_count=0 -> lives=0, state=OVER; start=0 -> INIT, lives reload 3.
//  T6 pellets_left=0 with simultaneous hit -> WIN, lives unchanged; pause (if _EN) freezes counter.

Source files
------------

// File: rtl/game_state_ctrl.sv
// Pac-Man game-flow controller: pac/ghost collisions, lives, respawn delay, win and game-over.
// Optional GAME_STATE_PAUSE_EN adds a `pause` input that freezes GAME and the RESUME countdown.
//
// state  | meaning
// INIT   | hold sprites/map/score in reset, reload lives, wait for start
// GAME   | normal play, collisions resolved each cycle
// RESUME | respawn delay after a lost life, sprites held at spawn
// OVER   | no lives left, wait for start to drop
// WIN    | map cleared, wait for start to drop
module game_state_ctrl #(
    parameter int NUM_GHOSTS    = 2,
    parameter int X_W           = 6,
    parameter int Y_W           = 5,
    parameter int PILL_W        = 33,
    parameter int PEL_W         = 10,
    parameter int LIVES_INIT    = 3,
    parameter int RESUME_CYCLES = 250000000
) (
    input  logic                       CLOCK_50,
    input  logic                       reset_n,
    input  logic                       start,
`ifdef GAME_STATE_PAUSE_EN
    input  logic                       pause,
`endif
    input  logic [X_W-1:0]             pac_x,
    input  logic [Y_W-1:0]             pac_y,
    input  logic [NUM_GHOSTS*X_W-1:0]  ghost_x,
    input  logic [NUM_GHOSTS*Y_W-1:0]  ghost_y,
    input  logic [PILL_W-1:0]          pill_count,
    input  logic [PEL_W-1:0]           pellets_left,
    output logic [2:0]                 lives,
    output logic [2:0]                 state,
    output logic                       sprite_reset,
    output logic                       map_wr_reset,
    output logic                       score_reset,
    output logic                       ghost_enable,
    output logic [NUM_GHOSTS-1:0]      ghost_eaten,
    output logic                       life_lost
);

    localparam int CNT_W = $clog2(RESUME_CYCLES);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_GAME   = 3'd1,
        S_RESUME = 3'd2,
        S_OVER   = 3'd3,
        S_WIN    = 3'd4
    } state_t;

    state_t                st;
    logic [CNT_W-1:0]      cnt;
    logic [NUM_GHOSTS-1:0] hit;
    logic [NUM_GHOSTS-1:0] hit_q;
    logic [NUM_GHOSTS-1:0] evt;
    logic                  paused;

`ifdef GAME_STATE_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            hit[i] = (ghost_x[i*X_W +: X_W] == pac_x) && (ghost_y[i*Y_W +: Y_W] == pac_y);
        end
    end

    // Only the first cycle of an overlap is an event, so a lingering ghost costs one life.
    assign evt   = hit & ~hit_q;
    assign state = st;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            st           <= S_INIT;
            lives        <= 3'(LIVES_INIT);
            cnt          <= '0;
            hit_q        <= '0;
            sprite_reset <= 1'b1;
            map_wr_reset <= 1'b1;
            score_reset  <= 1'b1;
            ghost_enable <= 1'b0;
            ghost_eaten  <= '0;
            life_lost    <= 1'b0;
        end else begin
            ghost_eaten <= '0;
            life_lost   <= 1'b0;
            case (st)
                S_INIT: begin
                    hit_q        <= '0;
                    lives        <= 3'(LIVES_INIT);
                    sprite_reset <= 1'b1;
                    map_wr_reset <= 1'b1;
                    score_reset  <= 1'b1;
                    ghost_enable <= 1'b0;
                    if (start) begin
                        st           <= S_GAME;
                        sprite_reset <= 1'b0;
                        map_wr_reset <= 1'b0;
                        score_reset  <= 1'b0;
                        ghost_enable <= 1'b1;
                    end
                end
                S_GAME: begin
                    sprite_reset <= 1'b0;
                    map_wr_reset <= 1'b0;
                    score_reset  <= 1'b0;
                    if (paused) begin
                        ghost_enable <= 1'b0;
                    end else begin
                        ghost_enable <= 1'b1;
                        hit_q        <= hit;
                        if (pellets_left == '0) begin
                            st           <= S_WIN;
                            hit_q        <= '0;
                            ghost_enable <= 1'b0;
                            map_wr_reset <= 1'b1;
                        end else if (|evt && pill_count != '0) begin
                            ghost_eaten <= evt;
                        end else if (|evt) begin
                            life_lost    <= 1'b1;
                            hit_q        <= '0;
                            ghost_enable <= 1'b0;
                            map_wr_reset <= 1'b1;
                            if (lives > 3'd1) begin
                                st           <= S_RESUME;
                                lives        <= lives - 3'd1;
                                cnt          <= CNT_W'(RESUME_CYCLES - 1);
                                sprite_reset <= 1'b1;
                            end else begin
                                st    <= S_OVER;
                                lives <= 3'd0;
                            end
                        end
                    end
                end
                S_RESUME: begin
                    hit_q        <= '0;
                    sprite_reset <= 1'b1;
                    map_wr_reset <= 1'b0;
                    score_reset  <= 1'b0;
                    ghost_enable <= 1'b0;
                    if (!paused) begin
                        if (cnt == '0) begin
                            st           <= S_GAME;
                            sprite_reset <= 1'b0;
                            ghost_enable <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                S_OVER, S_WIN: begin
                    hit_q        <= '0;
                    sprite_reset <= 1'b0;
                    map_wr_reset <= 1'b1;
                    score_reset  <= 1'b0;
                    ghost_enable <= 1'b0;
                    if (!start) begin
                        st           <= S_INIT;
                        lives        <= 3'(LIVES_INIT);
                        sprite_reset <= 1'b1;
                        score_reset  <= 1'b1;
                    end
                end
                default: st <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios plus a randomized run against a rule-level model.
module tb_game_state_ctrl;

    localparam int NG = 2, X_W = 6, Y_W = 5, PILL_W = 33, PEL_W = 10, LI = 3, RC = 8;
    localparam int P_INIT = 0, P_GAME = 1, P_RESUME = 2, P_OVER = 3, P_WIN = 4;

    logic CLOCK_50 = 1'b0;
    logic reset_n  = 1'b1;
    logic start    = 1'b0;
`ifdef GAME_STATE_PAUSE_EN
    logic pause    = 1'b0;
`endif
    logic [X_W-1:0]    pac_x;
    logic [Y_W-1:0]    pac_y;
    logic [X_W-1:0]    gx [NG];
    logic [Y_W-1:0]    gy [NG];
    logic [NG*X_W-1:0] ghost_x;
    logic [NG*Y_W-1:0] ghost_y;
    logic [PILL_W-1:0] pill_count;
    logic [PEL_W-1:0]  pellets_left;
    logic [2:0]        lives, state;
    logic              sprite_reset, map_wr_reset, score_reset, ghost_enable, life_lost;
    logic [NG-1:0]     ghost_eaten;

    int tests = 0;
    int fails = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    always_comb begin
        ghost_x = '0;
        ghost_y = '0;
        for (int i = 0; i < NG; i++) begin
            ghost_x[i*X_W +: X_W] = gx[i];
            ghost_y[i*Y_W +: Y_W] = gy[i];
        end
    end

    game_state_ctrl #(
        .NUM_GHOSTS(NG), .X_W(X_W), .Y_W(Y_W), .PILL_W(PILL_W), .PEL_W(PEL_W),
        .LIVES_INIT(LI), .RESUME_CYCLES(RC)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start),
`ifdef GAME_STATE_PAUSE_EN
        .pause(pause),
`endif
        .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
        .pill_count(pill_count), .pellets_left(pellets_left),
        .lives(lives), .state(state), .sprite_reset(sprite_reset), .map_wr_reset(map_wr_reset),
        .score_reset(score_reset), .ghost_enable(ghost_enable), .ghost_eaten(ghost_eaten),
        .life_lost(life_lost)
    );

    // Reference model: what the game should look like after each clock edge.
    int            m_phase = P_INIT, m_lives = LI, m_spent = 0;
    bit            m_touch [NG];
    logic [NG-1:0] m_eaten = '0;
    bit            m_ll = 0, m_sprite = 1, m_map = 1, m_score = 1, m_gen = 0;

    always @(posedge CLOCK_50 or negedge reset_n) begin : model
        logic [NG-1:0] fresh;
        bit            now_touch [NG];
        bit            frozen;
        if (!reset_n) begin
            m_phase = P_INIT; m_lives = LI; m_spent = 0; m_eaten = '0; m_ll = 0;
            m_sprite = 1; m_map = 1; m_score = 1; m_gen = 0;
            for (int i = 0; i < NG; i++) m_touch[i] = 0;
        end else begin
`ifdef GAME_STATE_PAUSE_EN
            frozen = pause;
`else
            frozen = 0;
`endif
            fresh = '0;
            for (int i = 0; i < NG; i++) begin
                now_touch[i] = (gx[i] == pac_x) && (gy[i] == pac_y);
                fresh[i]     = now_touch[i] && !m_touch[i];
            end
            m_eaten = '0;
            m_ll    = 0;
            if (m_phase == P_INIT) begin
                m_lives = LI;
                if (start) begin
                    m_phase = P_GAME; m_sprite = 0; m_map = 0; m_score = 0; m_gen = 1;
                end
            end else if (m_phase == P_GAME) begin
                if (frozen) m_gen = 0;
                else begin
                    m_gen = 1;
                    for (int i = 0; i < NG; i++) m_touch[i] = now_touch[i];
                    if (pellets_left == 0) begin
                        m_phase = P_WIN; m_gen = 0; m_map = 1;
                    end else if (fresh != 0 && pill_count != 0) begin
                        m_eaten = fresh;
                    end else if (fresh != 0) begin
                        m_ll = 1; m_gen = 0; m_map = 1;
                        if (m_lives >= 2) begin
                            m_lives--; m_phase = P_RESUME; m_spent = 0; m_sprite = 1;
                        end else begin
                            m_lives = 0; m_phase = P_OVER;
                        end
                    end
                end
            end else if (m_phase == P_RESUME) begin
                m_map = 0;
                if (!frozen) begin
                    m_spent++;
                    if (m_spent == RC) begin
                        m_phase = P_GAME; m_sprite = 0; m_gen = 1;
                    end
                end
            end else begin
                if (!start) begin
                    m_phase = P_INIT; m_lives = LI; m_sprite = 1; m_map = 1; m_score = 1;
                end
            end
            if (m_phase != P_GAME)
                for (int i = 0; i < NG; i++) m_touch[i] = 0;
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic idle_inputs();
        pac_x = 6'd5; pac_y = 5'd5;
        gx[0] = 6'd10; gy[0] = 5'd10;
        gx[1] = 6'd20; gy[1] = 5'd20;
        pill_count = '0; pellets_left = 10'd100;
`ifdef GAME_STATE_PAUSE_EN
        pause = 1'b0;
`endif
    endtask

    task automatic restart_game();
        idle_inputs();
        start = 1'b0;
        reset_n = 1'b0;
        #3;
        tick();
        reset_n = 1'b1;
        start = 1'b1;
        tick();
    endtask

    task automatic wait_game(output int n);
        n = 0;
        while (state != 3'd1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic lose_life(input int g);
        int n;
        gx[g] = pac_x; gy[g] = pac_y;
        tick();
        gx[g] = 6'd30 + 6'(g); gy[g] = 5'd25;
        if (state == 3'd2) wait_game(n);
    endtask

    task automatic test_reset();
        idle_inputs();
        start = 1'b0;
        #2 reset_n = 1'b0;
        #2;
        tests++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", state); end
        tests++; if (lives !== 3'd3) begin fails++; $display("FAIL reset_lives got %0d exp 3", lives); end
        tests++; if ({sprite_reset, map_wr_reset, score_reset, ghost_enable} !== 4'b1110) begin
            fails++; $display("FAIL reset_ctrl got %b exp 1110", {sprite_reset, map_wr_reset, score_reset, ghost_enable}); end
        tests++; if ({ghost_eaten, life_lost} !== 3'b000) begin
            fails++; $display("FAIL reset_pulses got %b exp 000", {ghost_eaten, life_lost}); end
        tick();
        reset_n = 1'b1;
        tick();
        tests++; if (state !== 3'd0) begin fails++; $display("FAIL init_hold got %0d exp 0", state); end
        start = 1'b1;
        tick();
        tests++; if (state !== 3'd1) begin fails++; $display("FAIL t1_state got %0d exp 1", state); end
        tests++; if (lives !== 3'd3) begin fails++; $display("FAIL t1_lives got %0d exp 3", lives); end
        tests++; if ({ghost_enable, sprite_reset, score_reset} !== 3'b100) begin
            fails++; $display("FAIL t1_ctrl got %b exp 100", {ghost_enable, sprite_reset, score_reset}); end
    endtask

    task automatic test_life_loss();
        int n;
        restart_game();
        gx[0] = pac_x; gy[0] = pac_y;
        tick();
        tests++; if ({state, lives, life_lost} !== {3'd2, 3'd2, 1'b1}) begin
            fails++; $display("FAIL t2_hit got st=%0d lives=%0d ll=%b exp st=2 lives=2 ll=1", state, lives, life_lost); end
        tests++; if ({map_wr_reset, sprite_reset, ghost_enable} !== 3'b110) begin
            fails++; $display("FAIL t2_resume_ctrl got %b exp 110", {map_wr_reset, sprite_reset, ghost_enable}); end
        n = 1;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (k == 0) begin
                tests++; if ({life_lost, map_wr_reset} !== 2'b00) begin
                    fails++; $display("FAIL t2_pulse_len got %b exp 00", {life_lost, map_wr_reset}); end
            end
            if (k == 7) begin gx[0] = 6'd10; gy[0] = 5'd10; end
            if (state == 3'd2) n++;
        end
        tests++; if (n !== RC) begin fails++; $display("FAIL t2_resume_cycles got %0d exp %0d", n, RC); end
        tests++; if ({state, ghost_enable, lives} !== {3'd1, 1'b1, 3'd2}) begin
            fails++; $display("FAIL t2_back st=%0d ge=%b lives=%0d exp st=1 ge=1 lives=2", state, ghost_enable, lives); end
    endtask

    task automatic test_double_hit();
        int n;
        restart_game();
        gx[0] = pac_x; gy[0] = pac_y; gx[1] = pac_x; gy[1] = pac_y;
        tick();
        tests++; if ({lives, life_lost} !== {3'd2, 1'b1}) begin
            fails++; $display("FAIL t3_lives got %0d ll=%b exp 2 ll=1", lives, life_lost); end
        gx[0] = 6'd10; gy[0] = 5'd10; gx[1] = 6'd20; gy[1] = 5'd20;
        wait_game(n);
        tests++; if ({state, lives} !== {3'd1, 3'd2}) begin
            fails++; $display("FAIL t3_after st=%0d lives=%0d exp st=1 lives=2", state, lives); end
    endtask

    task automatic test_frightened();
        restart_game();
        pill_count = 33'd50;
        gx[1] = pac_x; gy[1] = pac_y;
        tick();
        tests++; if ({ghost_eaten, state, lives, life_lost} !== {2'b10, 3'd1, 3'd3, 1'b0}) begin
            fails++; $display("FAIL t4_eat got ge=%b st=%0d lives=%0d ll=%b exp 10/1/3/0",
                              ghost_eaten, state, lives, life_lost); end
        tick();
        tests++; if (ghost_eaten !== 2'b00) begin fails++; $display("FAIL t4_pulse got %b exp 00", ghost_eaten); end
        gx[1] = 6'd20; gy[1] = 5'd20;
        pill_count = '0;
    endtask

    task automatic test_game_over();
        restart_game();
        lose_life(0);
        lose_life(1);
        tests++; if ({state, lives} !== {3'd1, 3'd1}) begin
            fails++; $display("FAIL t5_setup st=%0d lives=%0d exp 1/1", state, lives); end
        gx[0] = pac_x; gy[0] = pac_y;
        tick();
        tests++; if ({state, lives, life_lost, ghost_enable, map_wr_reset} !== {3'd3, 3'd0, 1'b1, 1'b0, 1'b1}) begin
            fails++; $display("FAIL t5_over st=%0d lives=%0d ll=%b ge=%b mw=%b exp 3/0/1/0/1",
                              state, lives, life_lost, ghost_enable, map_wr_reset); end
        gx[0] = 6'd10; gy[0] = 5'd10;
        tick();
        tests++; if ({state, lives} !== {3'd3, 3'd0}) begin
            fails++; $display("FAIL t5_hold st=%0d lives=%0d exp 3/0", state, lives); end
        start = 1'b0;
        tick();
        tests++; if ({state, lives} !== {3'd0, 3'd3}) begin
            fails++; $display("FAIL t5_reload st=%0d lives=%0d exp 0/3", state, lives); end
    endtask

    task automatic test_win();
        restart_game();
        pellets_left = '0;
        gx[0] = pac_x; gy[0] = pac_y;
        tick();
        tests++; if ({state, lives, life_lost} !== {3'd4, 3'd3, 1'b0}) begin
            fails++; $display("FAIL t6_win st=%0d lives=%0d ll=%b exp 4/3/0", state, lives, life_lost); end
        start = 1'b0;
        tick();
        tests++; if (state !== 3'd0) begin fails++; $display("FAIL t6_exit got %0d exp 0", state); end
    endtask

`ifdef GAME_STATE_PAUSE_EN
    task automatic test_pause();
        int n;
        restart_game();
        pause = 1'b1;
        tick();
        gx[0] = pac_x; gy[0] = pac_y;
        tick(); tick();
        tests++; if ({state, lives, ghost_enable, life_lost} !== {3'd1, 3'd3, 1'b0, 1'b0}) begin
            fails++; $display("FAIL pause_game st=%0d lives=%0d ge=%b ll=%b exp 1/3/0/0",
                              state, lives, ghost_enable, life_lost); end
        pause = 1'b0;
        tick();
        gx[0] = 6'd10; gy[0] = 5'd10;
        tests++; if ({state, lives} !== {3'd2, 3'd2}) begin
            fails++; $display("FAIL pause_release st=%0d lives=%0d exp 2/2", state, lives); end
        pause = 1'b1;
        repeat (5) tick();
        pause = 1'b0;
        wait_game(n);
        tests++; if (n !== RC) begin fails++; $display("FAIL pause_resume got %0d exp %0d", n, RC); end
    endtask
`endif

    task automatic test_random();
        restart_game();
        for (int c = 0; c < 1500; c++) begin
            start = ($urandom_range(0, 9) != 0);
            pac_x = X_W'($urandom_range(0, 2));
            pac_y = Y_W'($urandom_range(0, 1));
            for (int i = 0; i < NG; i++) begin
                gx[i] = X_W'($urandom_range(0, 2));
                gy[i] = Y_W'($urandom_range(0, 1));
            end
            pill_count   = ($urandom_range(0, 1) == 0) ? '0 : PILL_W'($urandom_range(1, 100));
            pellets_left = ($urandom_range(0, 59) == 0) ? '0 : PEL_W'($urandom_range(1, 500));
`ifdef GAME_STATE_PAUSE_EN
            pause = ($urandom_range(0, 9) == 0);
`endif
            tick();
            tests++; if (state !== 3'(m_phase)) begin fails++; $display("FAIL rnd_state c=%0d got %0d exp %0d", c, state, m_phase); end
            tests++; if (lives !== 3'(m_lives)) begin fails++; $display("FAIL rnd_lives c=%0d got %0d exp %0d", c, lives, m_lives); end
            tests++; if (ghost_eaten !== m_eaten) begin fails++; $display("FAIL rnd_eaten c=%0d got %b exp %b", c, ghost_eaten, m_eaten); end
            tests++; if (life_lost !== m_ll) begin fails++; $display("FAIL rnd_life_lost c=%0d got %b exp %b", c, life_lost, m_ll); end
            tests++; if ({ghost_enable, sprite_reset, map_wr_reset, score_reset} !== {m_gen, m_sprite, m_map, m_score}) begin
                fails++; $display("FAIL rnd_ctrl c=%0d got %b exp %b", c,
                                  {ghost_enable, sprite_reset, map_wr_reset, score_reset}, {m_gen, m_sprite, m_map, m_score}); end
        end
    endtask

    initial begin
        test_reset();
        test_life_loss();
        test_double_hit();
        test_frightened();
        test_game_over();
        test_win();
`ifdef GAME_STATE_PAUSE_EN
        test_pause();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
